drop_scheduler: RTL and testbench
=================================

# drop_scheduler

Sequencer for the tetris datapath. It drives the action and figure codes, the figure-load strobe and the register and memory write strobes. It arbitrates player move requests against a gravity timer and spawns new figures. It locks a figure when a down move is refused at a touch, and it detects game over. It sits between the player input logic and the border_regs/alu/memory datapath, in place of the instruction ROM/PC path.

## Interface
Parameters:
- WIDTH, 8: width of the action and figure codes.
- GRAVITY_PERIOD, 50: clock cycles between gravity DOWN requests. Must be at least 2.
- FIG_COUNT, 7: number of figure codes, 0..FIG_COUNT-1.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  1-cycle pulse that leaves IDLE.
- req_left  in  1  1-cycle pulse; move-left request.
- req_right  in  1  1-cycle pulse; move-right request.
- req_rot  in  1  1-cycle pulse; rotate request.
- is_move  in  1  from alu, combinational: the current action is legal.
- is_touch  in  1  from datapath, combinational: the figure rests on the border or floor.
- spawn_blocked  in  1  from datapath: the newly loaded figure overlaps the border.
- action  out  WIDTH  0 NOP, 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DOWN.
- figure  out  WIDTH  current figure code.
- is_load_fig  out  1  1-cycle strobe that loads the figure into border_regs.
- write_reg  out  1  1-cycle strobe that commits new_rho_x/new_rho_y.
- write_mem  out  1  1-cycle strobe that commits new_border to memory (lock).
- busy  out  1  high in every state except IDLE and OVER.
- game_over  out  1  high in OVER.
- pieces  out  16  count of locked figures; wraps from 0xFFFF to 0.

## Operation
- States: IDLE, SPAWN, SCHK, WAIT, ISSUE, COMMIT, LOCK, OVER.
- IDLE:
  - start goes to SPAWN.
  - Requests arriving in IDLE are dropped.
- SPAWN:
  - Drives figure = next_fig and is_load_fig = 1, then goes to SCHK.
  - Advances the figure generator.
- SCHK: samples spawn_blocked. If 1, goes to OVER; if 0, goes to WAIT.
- WAIT:
  - Holds action = NOP.
  - Leaves when any pending bit is set. The chosen request goes to ISSUE and its pending bit is cleared.
  - Priority: gravity DOWN > ROTATE > LEFT > RIGHT.
- ISSUE:
  - Drives the chosen action for one cycle and samples is_move and is_touch at the end of the cycle.
  - is_move = 1: go to COMMIT.
  - action = DOWN and is_move = 0 and is_touch = 1: go to LOCK.
  - Anything else: the request is discarded and the state returns to WAIT.
- COMMIT:
  - Holds the same action, pulses write_reg = 1, then returns to WAIT.
- LOCK:
  - Holds action = DOWN, pulses write_mem = 1, increments pieces, then goes to SPAWN.
  - Clears all pending bits.
- OVER:
  - Terminal state. Outputs are quiescent and game_over = 1.
  - Only reset leaves OVER.
- Pending bits (grav, rot, left, right):
  - Set by a request pulse or by the gravity wrap.
  - Set only while busy.
  - A bit that is already pending absorbs a repeat request; requests do not queue beyond one per kind.
  - A request that arrives in the cycle its bit is cleared is kept as pending.
- Gravity counter:
  - Counts 0..GRAVITY_PERIOD-1 while in WAIT, ISSUE or COMMIT.
  - Frozen in SPAWN, SCHK and LOCK.
  - Reset to 0 on every entry to SPAWN.
  - At wrap, grav goes pending.
- Figure generator: see Configuration. Its output is always in 0..FIG_COUNT-1 and is zero-extended to WIDTH.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: action = 0, figure = 0; is_load_fig, write_reg, write_mem, busy, game_over all 0; pieces = 0.
  - Internal: gravity counter 0, all pending bits 0, generator at its seed value.
- Asserting rst at any point, including mid-ISSUE or mid-LOCK, returns everything to the reset values immediately. No strobe may glitch during this.
- All outputs are registered.
- Strobes are exactly 1 cycle wide and never coincide; at most one strobe is high per cycle.
- Latencies:
  - start to is_load_fig: 1 cycle.
  - Request pulse to action driven: 2 cycles minimum (register to pending, WAIT, then ISSUE).
  - Legal move: 2 cycles of non-NOP action (ISSUE, COMMIT).
  - Lock: ISSUE, LOCK, SPAWN, SCHK.
- action is stable through ISSUE and COMMIT, so the alu outputs are stable when write_reg fires.

## Configuration
- RANDOM_FIG_EN defined:
  - next_fig comes from a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1.
  - The LFSR steps once per SPAWN.
  - next_fig = lfsr[7:0] mod FIG_COUNT.
- RANDOM_FIG_EN undefined:
  - next_fig cycles 0, 1, …, FIG_COUNT-1, 0, …, starting at 0 after reset.
  - No LFSR logic is synthesised.

## Test plan
- Reset and spawn:
  - Stimulus: release rst, then pulse start.
  - Required: is_load_fig = 1 one cycle later with figure = 0 (RANDOM_FIG_EN off). busy = 1 from then on.
- Legal move:
  - Stimulus: in WAIT, pulse req_left, with is_move = 1.
  - Required: action = 1 for 2 cycles; write_reg high on the second of them; return to WAIT with action = 0.
- Arbitration:
  - Stimulus: req_rot, req_right and a gravity wrap in the same cycle.
  - Required: DOWN issued first, then ROTATE, then RIGHT.
- Touch lock:
  - Stimulus: gravity DOWN with is_move = 0 and is_touch = 1.
  - Required: write_mem for 1 cycle; pieces 0→1; the next SPAWN gives figure = 1.
- Game over:
  - Stimulus: spawn_blocked = 1 in SCHK.
  - Required: game_over = 1 and busy = 0; later requests and start are ignored.
- Reset mid-operation:
  - Stimulus: assert rst during COMMIT.
  - Required: write_reg drops immediately; all outputs return to reset values; pieces = 0.

Source files
------------

// File: rtl/drop_scheduler.sv
// Tetris drop sequencer: arbitrates player moves against gravity, spawns, locks and detects game over.
// Define RANDOM_FIG_EN to draw figures from a 16-bit LFSR instead of the round-robin counter.
module drop_scheduler #(
    parameter int WIDTH          = 8,
    parameter int GRAVITY_PERIOD = 50,
    parameter int FIG_COUNT      = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             req_left,
    input  logic             req_right,
    input  logic             req_rot,
    input  logic             is_move,
    input  logic             is_touch,
    input  logic             spawn_blocked,
    output logic [WIDTH-1:0] action,
    output logic [WIDTH-1:0] figure,
    output logic             is_load_fig,
    output logic             write_reg,
    output logic             write_mem,
    output logic             busy,
    output logic             game_over,
    output logic [15:0]      pieces
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SPAWN  = 3'd1;
    localparam logic [2:0] S_SCHK   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_ISSUE  = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;
    localparam logic [2:0] S_LOCK   = 3'd6;
    localparam logic [2:0] S_OVER   = 3'd7;

    localparam logic [2:0] ACT_NOP   = 3'd0;
    localparam logic [2:0] ACT_LEFT  = 3'd1;
    localparam logic [2:0] ACT_RIGHT = 3'd2;
    localparam logic [2:0] ACT_ROT   = 3'd3;
    localparam logic [2:0] ACT_DOWN  = 3'd4;

    localparam int             CW      = $clog2(GRAVITY_PERIOD);
    localparam logic [CW-1:0]  CNT_MAX = CW'(GRAVITY_PERIOD - 1);

    logic [2:0]       r_state;
    logic [2:0]       r_act;
    logic [3:0]       r_pend;
    logic [CW-1:0]    r_grav_cnt;
    logic [2:0]       w_state_nxt;
    logic [2:0]       w_act_nxt;
    logic [2:0]       w_act_out;
    logic [3:0]       w_pend_clr;
    logic [3:0]       w_pend_set;
    logic             w_busy_cur;
    logic             w_counting;
    logic             w_grav_wrap;
    logic             w_spawn_entry;
    logic [WIDTH-1:0] w_next_fig;

    assign w_busy_cur    = (r_state != S_IDLE) && (r_state != S_OVER);
    assign w_counting    = (r_state == S_WAIT) || (r_state == S_ISSUE) || (r_state == S_COMMIT);
    assign w_grav_wrap   = w_counting && (r_grav_cnt == CNT_MAX);
    assign w_spawn_entry = (w_state_nxt == S_SPAWN);
    // Pending bits: {grav, rot, left, right}; a set in the clearing cycle wins.
    assign w_pend_set    = {w_grav_wrap, req_rot, req_left, req_right} & {4{w_busy_cur}};

`ifdef RANDOM_FIG_EN
    logic [15:0] r_lfsr;
    logic [31:0] w_lfsr_mod;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    assign w_lfsr_mod = {24'd0, r_lfsr[7:0]} % 32'(FIG_COUNT);
    assign w_next_fig = WIDTH'(w_lfsr_mod);

    // Figure LFSR, stepped once per spawn
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= 16'hACE1;
        end else if (w_spawn_entry) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end else begin
            r_lfsr <= r_lfsr;
        end
    end
`else
    logic [WIDTH-1:0] r_fig_cnt;

    assign w_next_fig = r_fig_cnt;

    // Round-robin figure counter, advanced once per spawn
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fig_cnt <= {WIDTH{1'b0}};
        end else if (w_spawn_entry) begin
            if (r_fig_cnt == WIDTH'(FIG_COUNT - 1)) begin
                r_fig_cnt <= {WIDTH{1'b0}};
            end else begin
                r_fig_cnt <= r_fig_cnt + WIDTH'(1);
            end
        end else begin
            r_fig_cnt <= r_fig_cnt;
        end
    end
`endif

    // Next-state, request selection and pending-clear decode
    always_comb begin
        w_state_nxt = r_state;
        w_act_nxt   = r_act;
        w_pend_clr  = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SPAWN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SPAWN: w_state_nxt = S_SCHK;
            S_SCHK: begin
                if (spawn_blocked) begin
                    w_state_nxt = S_OVER;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_pend[3]) begin
                    w_state_nxt = S_ISSUE;
                    w_act_nxt   = ACT_DOWN;
                    w_pend_clr  = 4'b1000;
                end else if (r_pend[2]) begin
                    w_state_nxt = S_ISSUE;
                    w_act_nxt   = ACT_ROT;
                    w_pend_clr  = 4'b0100;
                end else if (r_pend[1]) begin
                    w_state_nxt = S_ISSUE;
                    w_act_nxt   = ACT_LEFT;
                    w_pend_clr  = 4'b0010;
                end else if (r_pend[0]) begin
                    w_state_nxt = S_ISSUE;
                    w_act_nxt   = ACT_RIGHT;
                    w_pend_clr  = 4'b0001;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_ISSUE: begin
                if (is_move) begin
                    w_state_nxt = S_COMMIT;
                end else if ((r_act == ACT_DOWN) && is_touch) begin
                    w_state_nxt = S_LOCK;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_COMMIT: w_state_nxt = S_WAIT;
            S_LOCK: begin
                w_state_nxt = S_SPAWN;
                w_pend_clr  = 4'b1111;
            end
            S_OVER:  w_state_nxt = S_OVER;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Action driven in the upcoming state, so the registered output lines up with it
    always_comb begin
        w_act_out = ACT_NOP;
        case (w_state_nxt)
            S_ISSUE, S_COMMIT: w_act_out = w_act_nxt;
            S_LOCK:            w_act_out = ACT_DOWN;
            default:           w_act_out = ACT_NOP;
        endcase
    end

    // State, selected action and pending request bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_act   <= ACT_NOP;
            r_pend  <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_act   <= w_act_nxt;
            r_pend  <= (r_pend & ~w_pend_clr) | w_pend_set;
        end
    end

    // Gravity timer: runs only while a figure is in play, restarts on spawn
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grav_cnt <= {CW{1'b0}};
        end else if (w_spawn_entry || w_grav_wrap) begin
            r_grav_cnt <= {CW{1'b0}};
        end else if (w_counting) begin
            r_grav_cnt <= r_grav_cnt + CW'(1);
        end else begin
            r_grav_cnt <= r_grav_cnt;
        end
    end

    // Registered outputs decoded from the next state; strobes are one-hot by construction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            action      <= {WIDTH{1'b0}};
            figure      <= {WIDTH{1'b0}};
            is_load_fig <= 1'b0;
            write_reg   <= 1'b0;
            write_mem   <= 1'b0;
            busy        <= 1'b0;
            game_over   <= 1'b0;
            pieces      <= 16'd0;
        end else begin
            action      <= WIDTH'(w_act_out);
            is_load_fig <= (w_state_nxt == S_SPAWN);
            write_reg   <= (w_state_nxt == S_COMMIT);
            write_mem   <= (w_state_nxt == S_LOCK);
            busy        <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_OVER);
            game_over   <= (w_state_nxt == S_OVER);
            if (w_spawn_entry) begin
                figure <= w_next_fig;
            end else begin
                figure <= figure;
            end
            if ((w_state_nxt == S_LOCK) && (r_state != S_LOCK)) begin
                pieces <= pieces + 16'd1;
            end else begin
                pieces <= pieces;
            end
        end
    end

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler (default build, GRAVITY_PERIOD = 20): cycle-exact expected values.
module tb_drop_scheduler;

    logic       clk;
    logic       rst;
    logic       start;
    logic       req_left;
    logic       req_right;
    logic       req_rot;
    logic       is_move;
    logic       is_touch;
    logic       spawn_blocked;
    logic [7:0] action;
    logic [7:0] figure;
    logic       is_load_fig;
    logic       write_reg;
    logic       write_mem;
    logic       busy;
    logic       game_over;
    logic [15:0] pieces;

    int n_pass;
    int n_total;

    drop_scheduler #(
        .WIDTH(8),
        .GRAVITY_PERIOD(20),
        .FIG_COUNT(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .req_left(req_left),
        .req_right(req_right),
        .req_rot(req_rot),
        .is_move(is_move),
        .is_touch(is_touch),
        .spawn_blocked(spawn_blocked),
        .action(action),
        .figure(figure),
        .is_load_fig(is_load_fig),
        .write_reg(write_reg),
        .write_mem(write_mem),
        .busy(busy),
        .game_over(game_over),
        .pieces(pieces)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] act, input logic wr,
                             input logic wm, input logic ld, input logic bsy);
        check_value({tag, ".action"}, 32'(action), 32'(act));
        check_value({tag, ".write_reg"}, 32'(write_reg), 32'(wr));
        check_value({tag, ".write_mem"}, 32'(write_mem), 32'(wm));
        check_value({tag, ".is_load_fig"}, 32'(is_load_fig), 32'(ld));
        check_value({tag, ".busy"}, 32'(busy), 32'(bsy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b0;
        start = 1'b0;
        req_left = 1'b0;
        req_right = 1'b0;
        req_rot = 1'b0;
        is_move = 1'b0;
        is_touch = 1'b0;
        spawn_blocked = 1'b0;

        tick();
        tick();
        check_out("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_value("reset.figure", 32'(figure), 32'd0);
        check_value("reset.game_over", 32'(game_over), 32'd0);
        check_value("reset.pieces", 32'(pieces), 32'd0);

        rst = 1'b1;
        tick();
        check_out("idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        req_left = 1'b1;
        tick();
        req_left = 1'b0;
        check_out("idle_req", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Edge A: start sampled
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("spawn", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_value("spawn.figure", 32'(figure), 32'd0);
        tick();
        check_out("schk", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("wait0", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("idle_drop", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Legal left move
        req_left = 1'b1;
        is_move = 1'b1;
        tick();
        req_left = 1'b0;
        check_out("left_pend", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("left_issue", 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("left_commit", 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("left_back", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Arbitration: rot, right and gravity wrap together (wrap on edge A+22)
        repeat (14) tick();
        check_out("pre_wrap", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        req_rot = 1'b1;
        req_right = 1'b1;
        tick();
        req_rot = 1'b0;
        req_right = 1'b0;
        check_out("arb_wait", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("arb_down", 8'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("arb_down_c", 8'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("arb_w1", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("arb_rot", 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("arb_rot_c", 8'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("arb_w2", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("arb_right", 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("arb_right_c", 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        is_move = 1'b0;
        is_touch = 1'b1;
        tick();
        check_out("arb_w3", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Refused rotate at a touch is discarded, not locked
        req_rot = 1'b1;
        tick();
        req_rot = 1'b0;
        tick();
        check_out("disc_issue", 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("disc_back", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_value("disc.pieces", 32'(pieces), 32'd0);

        // Next gravity wrap on edge A+42, refused DOWN at touch locks
        repeat (8) tick();
        check_out("lk_wait", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("lk_issue", 8'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("lock", 8'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        check_value("lock.pieces", 32'(pieces), 32'd1);
        is_touch = 1'b0;
        tick();
        check_out("spawn2", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_value("spawn2.figure", 32'(figure), 32'd1);
        tick();
        tick();
        check_out("wait2", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during COMMIT
        req_left = 1'b1;
        is_move = 1'b1;
        tick();
        req_left = 1'b0;
        tick();
        check_out("mid_issue", 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("mid_commit", 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        check_out("rst_mid", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_value("rst_mid.pieces", 32'(pieces), 32'd0);
        check_value("rst_mid.figure", 32'(figure), 32'd0);
        check_value("rst_mid.game_over", 32'(game_over), 32'd0);
        tick();
        check_out("rst_hold", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        is_move = 1'b0;
        rst = 1'b1;
        tick();

        // Game over on a blocked spawn
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("spawn3", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_value("spawn3.figure", 32'(figure), 32'd0);
        spawn_blocked = 1'b1;
        tick();
        check_value("schk3.game_over", 32'(game_over), 32'd0);
        tick();
        spawn_blocked = 1'b0;
        check_out("over", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_value("over.game_over", 32'(game_over), 32'd1);
        start = 1'b1;
        req_rot = 1'b1;
        req_left = 1'b1;
        tick();
        start = 1'b0;
        req_rot = 1'b0;
        req_left = 1'b0;
        repeat (3) tick();
        check_out("over_hold", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_value("over_hold.game_over", 32'(game_over), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
